montgomery_mult_unit: RTL and testbench
=======================================

Name: montgomery_mult_unit

Overview:
- Pipelined word-level Montgomery multiplier, radix R = 2^BITS, computing P = A*B*R^-1 mod N using REDC.
- Core arithmetic primitive of the modular-exponentiation datapath; the square-and-multiply controller feeds it Montgomery-domain operands.
- Fixed 3-cycle latency; accepts one operation per cycle with no back-pressure.

Parameters:
- BITS, 64, operand/modulus width; R = 2^BITS.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operands A, B, N, N_prime valid this cycle
- A  in  BITS  multiplicand, Montgomery domain, A < N
- B  in  BITS  multiplier, Montgomery domain, B < N
- N  in  BITS  modulus; odd, N < R
- N_prime  in  BITS  -N^-1 mod R, precomputed by the caller
- out_valid  out  1  P holds a new result this cycle
- P  out  BITS  A*B*R^-1 mod N, fully reduced to [0, N)

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. While rst is sampled high:
  - out_valid = 0 and P = 0.
  - All pipeline valid bits are cleared, so in-flight operations are discarded.
  - Operands presented in the rst cycle are ignored.
- Stage 1, captured on the edge where in_valid = 1:
  - T = A*B, full 2*BITS-bit product.
  - N is registered alongside T.
  - T_lo = T mod R is multiplied by N_prime.
- Stage 2:
  - m = (T_lo*N_prime) mod R, keeping only the low BITS bits.
  - U = T + m*N, held to 2*BITS+1 bits with no truncation.
- Stage 3:
  - t = U >> BITS, which is BITS+1 bits wide.
  - If t >= N then P = t - N, else P = t.
  - The compare and subtract use BITS+1-bit arithmetic. The carry out of U must be kept, because t can reach 2N-1 > R-1.
- Latency and throughput:
  - Operands sampled at edge k give out_valid = 1 and P valid after edge k+3, for exactly one cycle per accepted operation.
  - Back-to-back in_valid is allowed; results come out in order, one per cycle.
  - There is no stall input. in_valid = 0 simply inserts a bubble.
- P holds its last value while out_valid = 0. It is updated only when a valid result leaves stage 3.
- N and N_prime may change on every accepted operation; each operation's own copies travel with it down the pipeline.
- Boundary cases:
  - A = 0 or B = 0 gives P = 0.
  - A = B = N-1 must be reduced correctly.
  - t == N exactly gives P = 0.
  - N = R-1 (largest odd modulus) must work, including the carry case.
- Out-of-contract inputs (even N, wrong N_prime, A or B >= N): P is unspecified but must be deterministic, and out_valid timing is unchanged.
- Pure datapath; no state machine beyond the valid shift register.

Test Plan:
- BITS=8, N=13, N_prime=59 (R^-1 mod 13 = 3; 1 in the Montgomery domain is 9):
  - A=9, B=9 -> P=9 with out_valid exactly 3 cycles after in_valid.
  - A=5, B=5 (2^2 in the domain) -> P=10; A=9, B=1 -> P=1 (domain exit); A=0, B=7 -> P=0.
- Back-to-back at BITS=8, N=13: three consecutive in_valid operations (9,9), (5,5), (9,1) -> out_valid high for 3 consecutive cycles with P = 9, 10, 1 in order.
- Reset mid-flight: assert rst one cycle after two accepted operations -> out_valid stays 0 and P = 0. After rst is released, a fresh (9,9) -> P=9 at latency 3.
- BITS=64, N = 2^64-59, N_prime = -N^-1 mod 2^64:
  - 1000 random A, B < N -> P matches a software REDC model.
  - Directed A = B = N-1 -> P = R^-1 mod N.
  - P < N is checked on every result.
- Carry and final-subtract coverage: pick operands whose t lands at >= R (U carry set) and at exactly N -> P correct (0 for the t = N case); cover bins for both subtract-taken and not-taken.

Source files
------------

// File: rtl/montgomery_mult_unit.sv
// montgomery_mult_unit
//   Pipelined word-level Montgomery multiplier (REDC), radix R = 2^BITS.
//   Computes P = A*B*R^-1 mod N, fully reduced to [0, N).
//   Fixed latency: operands sampled at edge k produce out_valid/P after
//   edge k+3. One operation per cycle, no back-pressure.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset (clears valid pipe, P = 0)
//   in_valid   A, B, N, N_prime valid this cycle
//   A, B       Montgomery-domain operands, < N
//   N          odd modulus, < R
//   N_prime    -N^-1 mod R
//   out_valid  P holds a new result this cycle
//   P          result; holds its last value while out_valid = 0
//
// Pipeline (register stages)
//   s1: T = A*B, N, N_prime
//   s2: m = (T_lo*N_prime) mod R, T, N
//   s3: t = (T + m*N) >> BITS   (BITS+1 bits, carry of U kept)
//   s4: P = (t >= N) ? t - N : t
module montgomery_mult_unit #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic [BITS-1:0] N,
  input  logic [BITS-1:0] N_prime,
  output logic            out_valid,
  output logic [BITS-1:0] P
);

  localparam int STAGES = 4;

  // valid shift register; bit i marks a live operation in stage i+1
  logic [STAGES-1:0] r_vld_pipe;

  logic [2*BITS-1:0] r1_t;
  logic [BITS-1:0]   r1_n;
  logic [BITS-1:0]   r1_np;

  logic [2*BITS-1:0] r2_t;
  logic [BITS-1:0]   r2_m;
  logic [BITS-1:0]   r2_n;

  logic [BITS:0]     r3_t;
  logic [BITS-1:0]   r3_n;

  logic [BITS-1:0]   r_p;

  logic [2*BITS-1:0] w_t;
  logic [BITS-1:0]   w_m;
  logic [2*BITS:0]   w_u;
  logic              w_ge;

  assign w_t = (2*BITS)'(A) * (2*BITS)'(B);

  // only the low BITS bits of T_lo*N_prime matter, so the product is
  // truncated to BITS bits
  assign w_m = r1_t[BITS-1:0] * r1_np;

  // U needs 2*BITS+1 bits: T + m*N can exceed 2^(2*BITS) when N is close
  // to R, and dropping that carry would corrupt t
  assign w_u = (2*BITS+1)'(r2_t) + (2*BITS+1)'(r2_m) * (2*BITS+1)'(r2_n);

  assign w_ge = (r3_t >= {1'b0, r3_n});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_p        <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-2:0], in_valid};
      if (r_vld_pipe[STAGES-2])
        r_p <= w_ge ? BITS'(r3_t - {1'b0, r3_n}) : r3_t[BITS-1:0];
    end
  end

  // datapath registers carry no reset; a cleared valid bit makes their
  // contents irrelevant
  always_ff @(posedge clk) begin
    r1_t  <= w_t;
    r1_n  <= N;
    r1_np <= N_prime;

    r2_t  <= r1_t;
    r2_m  <= w_m;
    r2_n  <= r1_n;

    r3_t  <= (BITS+1)'(w_u >> BITS);
    r3_n  <= r2_n;
  end

  assign out_valid = r_vld_pipe[STAGES-1];
  assign P         = r_p;

endmodule

// File: tb/tb_montgomery_mult_unit.sv
// Testbench for montgomery_mult_unit: a BITS=8 and a BITS=64 instance share
// clk/rst. Drivers push expected results into per-instance queues; a monitor
// pops and compares whenever out_valid is seen.
module tb_montgomery_mult_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic        v8,  ov8;
  logic [7:0]  a8, b8, n8, np8, p8;
  logic        v64, ov64;
  logic [63:0] a64, b64, n64, np64, p64;

  montgomery_mult_unit #(.BITS(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .N(n8),
    .N_prime(np8), .out_valid(ov8), .P(p8)
  );

  montgomery_mult_unit #(.BITS(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(v64), .A(a64), .B(b64), .N(n64),
    .N_prime(np64), .out_valid(ov64), .P(p64)
  );

  typedef struct {
    logic [63:0] p;
    logic [63:0] n;
    int          iss;
  } exp_t;

  exp_t q[2][$];

  int cov_carry = 0, cov_sub = 0, cov_nosub = 0, cov_teqn = 0;

  logic [63:0] last8 = '0, last64 = '0;

  // A*B*R^-1 mod N: reduce A*B mod N, then divide by 2 modulo N, bits times
  function automatic logic [63:0] ref_mont(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] n, input int bits);
    logic [127:0] x;
    x = ({64'b0, a} * {64'b0, b}) % {64'b0, n};
    for (int i = 0; i < bits; i++)
      x = x[0] ? ((x + {64'b0, n}) >> 1) : (x >> 1);
    return x[63:0];
  endfunction

  // -N^-1 mod 2^bits via Newton iteration
  function automatic logic [63:0] nprime(input logic [63:0] n, input int bits);
    logic [63:0] x;
    x = n;
    repeat (6) x = x * (64'd2 - n * x);
    x = -x;
    if (bits < 64) x = x & ((64'd1 << bits) - 64'd1);
    return x;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic iss8(input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] n, input logic [63:0] np);
    exp_t e;
    @(negedge clk);
    v8 = 1'b1; v64 = 1'b0;
    a8 = a[7:0]; b8 = b[7:0]; n8 = n[7:0]; np8 = np[7:0];
    e.p = ref_mont(a, b, n, 8); e.n = n; e.iss = cyc + 1;
    q[0].push_back(e);
  endtask

  task automatic iss64(input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] n, input logic [63:0] np);
    exp_t e;
    logic [127:0] t_full, mn;
    logic [63:0]  m;
    logic [128:0] u;
    logic [64:0]  t;
    @(negedge clk);
    v64 = 1'b1; v8 = 1'b0;
    a64 = a; b64 = b; n64 = n; np64 = np;
    e.p = ref_mont(a, b, n, 64); e.n = n; e.iss = cyc + 1;
    q[1].push_back(e);
    // classify the unreduced value t for coverage reporting
    t_full = {64'b0, a} * {64'b0, b};
    m  = t_full[63:0] * np;
    mn = {64'b0, m} * {64'b0, n};
    u  = {1'b0, t_full} + {1'b0, mn};
    t  = u[128:64];
    if (t[64]) cov_carry++;
    if (t >= {1'b0, n}) cov_sub++; else cov_nosub++;
    if (t == {1'b0, n}) cov_teqn++;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      v8 = 1'b0; v64 = 1'b0;
    end
  endtask

  task automatic mon(input int id, input logic ov, input logic [63:0] p,
                     input logic rs, inout logic [63:0] last);
    exp_t e;
    if (ov) begin
      if (q[id].size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out dut%0d actual=out_valid=1 required=no pending result (t=%0t)",
                 id, $time);
      end else begin
        e = q[id].pop_front();
        chk($sformatf("P dut%0d", id), p, e.p);
        chk($sformatf("latency dut%0d", id), 64'(cyc - e.iss), 64'd3);
        chk($sformatf("P_lt_N dut%0d", id), 64'(p < e.n), 64'd1);
      end
    end else begin
      chk($sformatf("P_hold dut%0d", id), p, rs ? 64'd0 : last);
    end
    last = p;
  endtask

  // monitor: sample 1 time unit after each active edge
  initial begin
    logic rs;
    forever begin
      @(posedge clk);
      rs = rst;
      #1;
      mon(0, ov8, {56'b0, p8}, rs, last8);
      mon(1, ov64, p64, rs, last64);
    end
  end

  initial begin
    logic [63:0] n0, np0, n, np, a, b;
    rst = 1'b1; v8 = 1'b0; v64 = 1'b0;
    a8 = '0; b8 = '0; n8 = '0; np8 = '0;
    a64 = '0; b64 = '0; n64 = '0; np64 = '0;

    @(posedge clk); #1;
    chk("rst_ov8", {63'b0, ov8}, 64'd0);
    chk("rst_p8", {56'b0, p8}, 64'd0);
    chk("rst_ov64", {63'b0, ov64}, 64'd0);
    chk("rst_p64", p64, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // BITS=8 directed, N=13, N_prime=59
    iss8(9, 9, 13, 59);  idle(4);
    iss8(5, 5, 13, 59);  idle(1);
    iss8(9, 1, 13, 59);  idle(2);
    iss8(0, 7, 13, 59);  idle(4);
    // back-to-back
    iss8(9, 9, 13, 59);
    iss8(5, 5, 13, 59);
    iss8(9, 1, 13, 59);
    idle(4);
    // A = B = N-1, t == N (N=15: 3*5 is a multiple of N)
    iss8(12, 12, 13, 59);
    iss8(3, 5, 15, 17);
    iss8(7, 0, 15, 17);
    idle(4);

    // reset one cycle after two accepted operations
    iss8(9, 9, 13, 59);
    iss8(5, 5, 13, 59);
    @(negedge clk);
    v8 = 1'b0; v64 = 1'b0; rst = 1'b1;
    q[0].delete(); q[1].delete();
    @(posedge clk); #1;
    chk("midrst_ov8", {63'b0, ov8}, 64'd0);
    chk("midrst_p8", {56'b0, p8}, 64'd0);
    @(posedge clk); #1;
    chk("midrst_ov8_2", {63'b0, ov8}, 64'd0);
    chk("midrst_p8_2", {56'b0, p8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    iss8(9, 9, 13, 59);
    idle(4);

    // BITS=64, N = 2^64-59
    n0  = 64'hFFFF_FFFF_FFFF_FFC5;
    np0 = nprime(n0, 64);
    iss64(n0 - 64'd1, n0 - 64'd1, n0, np0);
    iss64(64'd0, rand64() % n0, n0, np0);
    iss64(64'd1, 64'd1, n0, np0);
    // N = R-1: t == N exactly with A*B = N
    iss64(64'd3, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, nprime(64'hFFFF_FFFF_FFFF_FFFF, 64));
    for (int i = 0; i < 1000; i++) begin
      a = rand64() % n0;
      b = rand64() % n0;
      iss64(a, b, n0, np0);
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    // N = R-1 exercises the U carry heavily
    n  = 64'hFFFF_FFFF_FFFF_FFFF;
    np = nprime(n, 64);
    iss64(n - 64'd1, n - 64'd1, n, np);
    for (int i = 0; i < 200; i++) begin
      iss64(rand64() % n, rand64() % n, n, np);
    end

    // per-operation modulus changes
    for (int i = 0; i < 200; i++) begin
      n  = rand64() | 64'd1;
      if (n == 64'd1) n = 64'd3;
      np = nprime(n, 64);
      iss64(rand64() % n, rand64() % n, n, np);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // random 8-bit traffic with mixed odd moduli
    for (int i = 0; i < 200; i++) begin
      n  = 64'($urandom_range(1, 127)) * 64'd2 + 64'd1;
      iss8(64'($urandom) % n, 64'($urandom) % n, n, nprime(n, 8));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    idle(2);
    for (int i = 0; i < 20 && (q[0].size() != 0 || q[1].size() != 0); i++)
      @(negedge clk);
    chk("drain_q8", 64'(q[0].size()), 64'd0);
    chk("drain_q64", 64'(q[1].size()), 64'd0);

    $display("coverage carry=%0d sub_taken=%0d sub_not_taken=%0d t_eq_n=%0d",
             cov_carry, cov_sub, cov_nosub, cov_teqn);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
